// File: rtl/lsu.sv
// RV32I load/store unit for the memory stage: drives the synchronous data RAM or the
// fifo_if MMIO window, returns extended load data and stalls the PC while busy.
module lsu #(
    parameter int unsigned DMEM_AW   = 10,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    input  logic               req_we_i,
    input  logic [2:0]         req_funct3_i,
    input  logic [31:0]        req_addr_i,
    input  logic [31:0]        req_wdata_i,
    output logic               stall_o,
    output logic               done_o,
    output logic [31:0]        rdata_o,
    output logic               fault_o,
    output logic               mem_en_o,
    output logic [3:0]         mem_be_o,
    output logic [DMEM_AW-1:0] mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    input  logic [31:0]        mem_rdata_i,
    output logic               fifo_sel_o,
    output logic               fifo_rd_o,
    output logic               fifo_wr_o,
    output logic [1:0]         fifo_addr_o,
    output logic [7:0]         fifo_wdata_o,
    input  logic [7:0]         fifo_rdata_i
);

    localparam int unsigned AQ_W = DMEM_AW + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic              mmio_q, mmio_d;
    logic [2:0]        f3_q, f3_d;
    logic [AQ_W-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              req_mmio;
    logic              req_fault;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

    // Legality of the incoming request: funct3, alignment and MMIO size/offset rules
    always_comb begin
        req_mmio  = (req_addr_i[31:4] == MMIO_BASE[31:4]);
        req_fault = 1'b0;
        case (req_funct3_i)
            3'b000:  req_fault = 1'b0;
            3'b001:  req_fault = req_addr_i[0] | req_mmio;
            3'b010:  req_fault = (req_addr_i[1:0] != 2'b00);
            3'b100:  req_fault = req_we_i;
            3'b101:  req_fault = req_we_i | req_addr_i[0] | req_mmio;
            default: req_fault = 1'b1;
        endcase
        if (req_mmio && (req_addr_i[1:0] != 2'b00)) begin
            req_fault = 1'b1;
        end
    end

    // Store lane enables with the datum replicated across lanes
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    // Load lane select and extension; MMIO always returns a single byte
    always_comb begin
        ld_byte = mmio_q ? fifo_rdata_i : mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = mmio_q ? {24'h0, ld_byte} : mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            mmio_q  <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            mmio_q  <= mmio_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state and outputs; strobes depend only on state and the latched request
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        mmio_d       = mmio_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        rdata_o      = 32'h0;
        fault_o      = 1'b0;
        mem_en_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = '0;
        mem_wdata_o  = 32'h0;
        fifo_sel_o   = 1'b0;
        fifo_rd_o    = 1'b0;
        fifo_wr_o    = 1'b0;
        fifo_addr_o  = 2'b00;
        fifo_wdata_o = 8'h00;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    stall_o = ~rst_i;
                    we_d    = req_we_i;
                    mmio_d  = req_mmio;
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i[AQ_W-1:0];
                    wdata_d = req_wdata_i;
                    state_d = req_fault ? FAULT : ISSUE;
                end
            end
            ISSUE: begin
                if (mmio_q) begin
                    fifo_sel_o  = 1'b1;
                    fifo_rd_o   = ~we_q;
                    fifo_wr_o   = we_q;
                    fifo_addr_o = addr_q[3:2];
                    if (we_q) begin
                        fifo_wdata_o = wdata_q[7:0];
                    end
                end else begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = addr_q[AQ_W-1:2];
                    if (we_q) begin
                        mem_be_o    = st_be;
                        mem_wdata_o = st_wdata;
                    end
                end
                if (we_q) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                done_o  = 1'b1;
                rdata_o = ld_data;
                state_d = IDLE;
            end
            FAULT: begin
                done_o  = 1'b1;
                fault_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus random traffic checked
// against a byte-addressed memory / MMIO reference model.
module tb_lsu;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        fault_o;
    logic        mem_en_o;
    logic [3:0]  mem_be_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        fifo_sel_o;
    logic        fifo_rd_o;
    logic        fifo_wr_o;
    logic [1:0]  fifo_addr_o;
    logic [7:0]  fifo_wdata_o;
    logic [7:0]  fifo_rdata_i;

    int vectors;
    int miscompares;

    lsu #(.DMEM_AW(10), .MMIO_BASE(32'hF000_0000)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .fault_o      (fault_o),
        .mem_en_o     (mem_en_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .fifo_sel_o   (fifo_sel_o),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_wr_o    (fifo_wr_o),
        .fifo_addr_o  (fifo_addr_o),
        .fifo_wdata_o (fifo_wdata_o),
        .fifo_rdata_i (fifo_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: synchronous word RAM and a fifo_if that returns fifo_val on read
    logic [31:0] ram [1024];
    logic [7:0]  fifo_val;

    always @(posedge clk) begin
        if (mem_en_o) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be_o[k]) ram[mem_addr_o][8*k +: 8] <= mem_wdata_o[8*k +: 8];
            end
            mem_rdata_i <= ram[mem_addr_o];
        end
        if (fifo_rd_o) fifo_rdata_i <= fifo_val;
    end

    logic strobes_on;
    logic outs_zero;
    assign strobes_on = mem_en_o | (|mem_be_o) | fifo_sel_o | fifo_rd_o | fifo_wr_o;
    assign outs_zero  = !(stall_o | done_o | fault_o | (|rdata_o) | strobes_on |
                          (|mem_addr_o) | (|mem_wdata_o) | (|fifo_addr_o) | (|fifo_wdata_o));

    typedef struct packed {
        logic        stall_t, quiet_t, stall_t1, done_t1, fault_t1;
        logic        stall_t2, done_t2, fault_t2, quiet_t2;
        logic        mem_en;
        logic [3:0]  be;
        logic [9:0]  maddr;
        logic [31:0] mwdata;
        logic        fsel, frd, fwr;
        logic [1:0]  faddr;
        logic [7:0]  fwdata;
        logic [31:0] rdata;
    } obs_t;

    // Reference model: byte-addressed 4 KiB RAM, addresses wrap modulo its size
    logic [7:0] ref_mem [4096];

    function automatic obs_t ref_op(input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [7:0] fv);
        obs_t        e;
        int          size;
        int          ofs;
        logic        legal, mmio, flt;
        logic [31:0] v;
        logic [11:0] a12;
        e = '0;
        e.stall_t  = 1'b1;
        e.quiet_t  = 1'b1;
        e.quiet_t2 = 1'b1;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ofs   = int'(addr[1:0]);
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        mmio  = (addr[31:4] == 28'hF00_0000);
        flt   = !legal || (ofs % size != 0) || (mmio && (size == 2 || ofs != 0));
        if (flt) begin
            e.done_t1  = 1'b1;
            e.fault_t1 = 1'b1;
        end else if (we) begin
            e.done_t1 = 1'b1;
            if (mmio) begin
                e.fsel   = 1'b1;
                e.fwr    = 1'b1;
                e.faddr  = addr[3:2];
                e.fwdata = wd[7:0];
            end else begin
                e.mem_en = 1'b1;
                e.maddr  = addr[11:2];
                for (int k = 0; k < 4; k++) begin
                    e.be[k] = (k >= ofs) && (k < ofs + size);
                    e.mwdata[8*k +: 8] = wd[8*(k % size) +: 8];
                end
                for (int i = 0; i < size; i++) begin
                    a12 = addr[11:0] + 12'(i);
                    ref_mem[a12] = wd[8*i +: 8];
                end
            end
        end else begin
            e.stall_t1 = 1'b1;
            e.done_t2  = 1'b1;
            v = 32'h0;
            if (mmio) begin
                e.fsel  = 1'b1;
                e.frd   = 1'b1;
                e.faddr = addr[3:2];
                v = (f3 == 3'd0) ? {{24{fv[7]}}, fv} : {24'h0, fv};
            end else begin
                e.mem_en = 1'b1;
                e.maddr  = addr[11:2];
                for (int i = 0; i < size; i++) begin
                    a12 = addr[11:0] + 12'(i);
                    v[8*i +: 8] = ref_mem[a12];
                end
                if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            end
            e.rdata = v;
        end
        return e;
    endfunction

    // Drives one request starting in an IDLE cycle and records what the DUT showed
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output obs_t o);
        o = '0;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        #1;
        o.stall_t = stall_o;
        o.quiet_t = !(done_o | fault_o | (|rdata_o) | strobes_on);
        @(negedge clk);
        o.stall_t1 = stall_o;
        o.done_t1  = done_o;
        o.fault_t1 = fault_o;
        o.mem_en   = mem_en_o;
        o.be       = mem_be_o;
        o.maddr    = mem_en_o ? mem_addr_o : 10'h0;
        o.mwdata   = (|mem_be_o) ? mem_wdata_o : 32'h0;
        o.fsel     = fifo_sel_o;
        o.frd      = fifo_rd_o;
        o.fwr      = fifo_wr_o;
        o.faddr    = fifo_sel_o ? fifo_addr_o : 2'b00;
        o.fwdata   = fifo_wr_o ? fifo_wdata_o : 8'h00;
        if (done_o) begin
            o.rdata     = rdata_o;
            o.quiet_t2  = 1'b1;
            req_valid_i = 1'b0;
        end else begin
            @(negedge clk);
            o.stall_t2  = stall_o;
            o.done_t2   = done_o;
            o.fault_t2  = fault_o;
            o.rdata     = rdata_o;
            o.quiet_t2  = !strobes_on;
            req_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i  = 32'h10;
        req_wdata_i = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (outs_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: stall=%b done=%b strobes=%b rdata=%h, required all zero",
                     stall_o, done_o, strobes_on, rdata_o);
        end
        repeat (2) @(negedge clk);
        req_valid_i = 1'b0;
        rst_i       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (outs_zero !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_outputs: stall=%b done=%b strobes=%b, required all zero",
                         stall_o, done_o, strobes_on);
            end
        end
    endtask

    task automatic test_sw_lw();
        obs_t o, e;
        e = ref_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 8'h00);
        run_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, o);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL sw_0x10: got %h want %h", o, e); end
        vectors++;
        if (o.be !== 4'b1111 || o.maddr !== 10'd4 || o.done_t1 !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_strobes: be=%b addr=%0d done=%b, required 1111 4 1", o.be, o.maddr, o.done_t1);
        end
        e = ref_op(1'b0, 3'b010, 32'h10, 32'h0, 8'h00);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, o);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL lw_0x10: got %h want %h", o, e); end
        vectors++;
        if (o.rdata !== 32'hDEAD_BEEF || o.done_t2 !== 1'b1 || {o.stall_t, o.stall_t1, o.stall_t2} !== 3'b110) begin
            miscompares++;
            $display("FAIL lw_result: rdata=%h done=%b stalls=%b%b%b, required deadbeef 1 110",
                     o.rdata, o.done_t2, o.stall_t, o.stall_t1, o.stall_t2);
        end
    endtask

    task automatic test_subword();
        obs_t o, e;
        logic [31:0] want [4];
        logic        we_t [4];
        logic [2:0]  f3_t [4];
        logic [31:0] ad_t [4];
        we_t = '{1'b1, 1'b0, 1'b0, 1'b0};
        f3_t = '{3'b000, 3'b000, 3'b100, 3'b001};
        ad_t = '{32'h13, 32'h13, 32'h13, 32'h12};
        want = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AD};
        for (int i = 0; i < 4; i++) begin
            e = ref_op(we_t[i], f3_t[i], ad_t[i], 32'h80, 8'h00);
            run_op(we_t[i], f3_t[i], ad_t[i], 32'h80, o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL subword_%0d: got %h want %h", i, o, e); end
            vectors++;
            if (i == 0 && (o.be !== 4'b1000 || o.mwdata !== 32'h8080_8080)) begin
                miscompares++;
                $display("FAIL sb_lanes: be=%b wdata=%h, required 1000 80808080", o.be, o.mwdata);
            end else if (i > 0 && o.rdata !== want[i]) begin
                miscompares++;
                $display("FAIL subload_%0d: rdata=%h, required %h", i, o.rdata, want[i]);
            end
        end
    endtask

    task automatic test_faults();
        obs_t o, e;
        logic        we_t [5];
        logic [2:0]  f3_t [5];
        logic [31:0] ad_t [5];
        we_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        f3_t = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b111};
        ad_t = '{32'h11, 32'h13, 32'h10, 32'h20, 32'h24};
        for (int i = 0; i < 5; i++) begin
            e = ref_op(we_t[i], f3_t[i], ad_t[i], 32'h5555_AAAA, 8'h00);
            run_op(we_t[i], f3_t[i], ad_t[i], 32'h5555_AAAA, o);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL fault_%0d: got %h want %h", i, o, e); end
            vectors++;
            if (o.done_t1 !== 1'b1 || o.fault_t1 !== 1'b1 || o.rdata !== 32'h0 || o.mem_en !== 1'b0 || o.fsel !== 1'b0) begin
                miscompares++;
                $display("FAIL fault_flags_%0d: done=%b fault=%b rdata=%h mem_en=%b sel=%b, required 1 1 0 0 0",
                         i, o.done_t1, o.fault_t1, o.rdata, o.mem_en, o.fsel);
            end
        end
    endtask

    task automatic test_mmio();
        obs_t o, e;
        e = ref_op(1'b1, 3'b000, 32'hF000_0004, 32'h0000_0041, 8'h00);
        run_op(1'b1, 3'b000, 32'hF000_0004, 32'h0000_0041, o);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL mmio_sb: got %h want %h", o, e); end
        vectors++;
        if ({o.fsel, o.fwr, o.faddr, o.fwdata} !== {1'b1, 1'b1, 2'd1, 8'h41} || o.mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mmio_sb_strobes: sel=%b wr=%b addr=%0d data=%h mem_en=%b, required 1 1 1 41 0",
                     o.fsel, o.fwr, o.faddr, o.fwdata, o.mem_en);
        end
        fifo_val = 8'hC3;
        e = ref_op(1'b0, 3'b100, 32'hF000_0000, 32'h0, fifo_val);
        run_op(1'b0, 3'b100, 32'hF000_0000, 32'h0, o);
        vectors++;
        if (o.rdata !== 32'h0000_00C3 || o.mem_en !== 1'b0 || o.frd !== 1'b1) begin
            miscompares++;
            $display("FAIL mmio_lbu: rdata=%h mem_en=%b rd=%b, required 000000c3 0 1", o.rdata, o.mem_en, o.frd);
        end
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL mmio_lbu_model: got %h want %h", o, e); end
        e = ref_op(1'b1, 3'b001, 32'hF000_0000, 32'h1234, 8'h00);
        run_op(1'b1, 3'b001, 32'hF000_0000, 32'h1234, o);
        vectors++;
        if (o !== e || o.fault_t1 !== 1'b1) begin miscompares++; $display("FAIL mmio_sh: got %h want %h", o, e); end
    endtask

    task automatic test_reset_mid_load();
        obs_t o, e;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h10;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        #1;
        vectors++;
        if (outs_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_wait: done=%b stall=%b rdata=%h, required all zero", done_o, stall_o, rdata_o);
        end
        @(negedge clk);
        vectors++;
        if (outs_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_held: done=%b stall=%b strobes=%b, required all zero", done_o, stall_o, strobes_on);
        end
        req_valid_i = 1'b0;
        rst_i       = 1'b0;
        e = ref_op(1'b0, 3'b010, 32'h10, 32'h0, 8'h00);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, o);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL lw_after_reset: got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic        we_t [4];
        logic [2:0]  f3_t [4];
        logic [31:0] ad_t [4];
        logic [31:0] wd_t [4];
        we_t = '{1'b1, 1'b0, 1'b1, 1'b0};
        f3_t = '{3'b010, 3'b010, 3'b000, 3'b010};
        ad_t = '{32'h1010, 32'h0010, 32'h2011, 32'h3010};
        wd_t = '{32'h1234_5678, 32'h0, 32'h0000_005A, 32'h0};
        for (int i = 0; i < 4; i++) begin
            e = ref_op(we_t[i], f3_t[i], ad_t[i], wd_t[i], 8'h00);
            run_op(we_t[i], f3_t[i], ad_t[i], wd_t[i], o);
            vectors++;
            if (o !== e || o.maddr !== 10'd4) begin
                miscompares++;
                $display("FAIL b2b_%0d: got %h want %h", i, o, e);
            end
        end
        vectors++;
        if (o.rdata !== 32'h1234_5A78) begin
            miscompares++;
            $display("FAIL b2b_wrap_data: rdata=%h, required 12345a78", o.rdata);
        end
    endtask

    task automatic test_random();
        obs_t        o, e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            case ($urandom_range(0, 3))
                0: addr = 32'hF000_0000 | 32'($urandom_range(0, 15));
                1: addr = 32'hF000_0010 | 32'($urandom_range(0, 15));
                default: addr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2) |
                                32'($urandom_range(0, 3));
            endcase
            fifo_val = 8'($urandom);
            e = ref_op(we, f3, addr, wd, fifo_val);
            run_op(we, f3, addr, wd, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rand_%0d we=%b f3=%b addr=%h: got %h want %h", n, we, f3, addr, o, e);
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        fifo_val     = 8'h00;
        mem_rdata_i  = 32'h0;
        fifo_rdata_i = 8'h00;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_sw_lw();
        test_subword();
        test_faults();
        test_mmio();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
